// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: sequences cache lookups, delivers hits, and refills misses byte-wise from memory.
// Optional ICTRL_FILL_BYPASS_EN delivers the refilled word in the same cycle as the cache write.
module icache_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        iq_full,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] icache_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_inst,
    output logic        fill_en,
    output logic [31:0] fill_addr,
    output logic [31:0] fill_inst,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [1:0] {FETCH, REQ, READ} state_t;

    state_t      state, state_n;
    logic [31:0] pc, full_word;
    logic [23:0] word;
    logic [2:0]  cnt;
    logic        hit_go, miss_go, gnt_go, done, bypass;

    assign icache_addr = pc;

    // A fill being written this cycle is not yet visible, so FETCH idles rather than re-missing.
    always_comb begin
        hit_go = state == FETCH && icache_hit && !iq_full && !fill_en;
        miss_go = state == FETCH && !icache_hit && !fill_en;
        gnt_go = state == REQ && mem_gnt;
        done = state == READ && cnt == 3'd4;
`ifdef ICTRL_FILL_BYPASS_EN
        bypass = done && !iq_full;
`else
        bypass = 1'b0;
`endif
        full_word = {mem_rdata, word};
        state_n = jump_en ? FETCH : miss_go ? REQ : gnt_go ? READ : done ? FETCH : state;
        mem_addr = 32'h0;
        // While frozen, repeat the last presented address so the byte arriving on resume is the one owed.
        if (gnt_go && rdy)
            mem_addr = pc;
        else if (state == READ)
            mem_addr = !rdy ? pc + {29'b0, cnt} - 32'd1 : cnt != 3'd4 ? pc + {29'b0, cnt} : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else if (rdy)
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            inst_valid <= 1'b0;
            inst <= 32'h0;
            inst_pc <= 32'h0;
            fill_en <= 1'b0;
            fill_addr <= 32'h0;
            fill_inst <= 32'h0;
            mem_req <= 1'b0;
            cnt <= 3'd0;
            word <= 24'h0;
        end else if (!rdy) begin
            inst_valid <= 1'b0;
            fill_en <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            fill_en <= 1'b0;
            if (jump_en) begin
                pc <= jump_addr & ~32'h3;
                mem_req <= 1'b0;
                cnt <= 3'd0;
            end else begin
                if (hit_go || bypass) begin
                    inst_valid <= 1'b1;
                    inst <= hit_go ? icache_inst : full_word;
                    inst_pc <= pc;
                    pc <= pc + 32'd4;
                end
                if (miss_go)
                    mem_req <= 1'b1;
                if (gnt_go)
                    cnt <= 3'd1;
                if (state == READ) begin
                    case (cnt)
                        3'd1: word[7:0] <= mem_rdata;
                        3'd2: word[15:8] <= mem_rdata;
                        3'd3: word[23:16] <= mem_rdata;
                        default: ;
                    endcase
                    cnt <= cnt + 3'd1;
                    if (done) begin
                        fill_en <= 1'b1;
                        fill_addr <= pc;
                        fill_inst <= full_word;
                        mem_req <= 1'b0;
                        cnt <= 3'd0;
                    end
                end
            end
        end
    end
endmodule
